elbeth_mem_arbiter: RTL

Arbitrates the core's instruction-fetch port and data-access port onto a single shared memory bus. It captures one request at a time, drives the bus until the slave answers with ready or error, and routes the response back to the requester that owns the transaction. Data accesses have priority, bounded by a starvation guard for fetch. A timeout watchdog converts a hung bus into an error.

---
 rtl/elbeth_mem_arbiter.sv | 112 +++++++++++
 1 files changed

// File: rtl/elbeth_mem_arbiter.sv
// Shared memory bus arbiter: fetch and data ports multiplexed onto one bus.
// Data wins by default; a streak limit keeps a pending fetch from starving.
// A watchdog turns a silent bus into an error completion.
module elbeth_mem_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES  = 255,
    parameter int unsigned MAX_DMEM_STREAK = 4
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        imem_en,
    input  logic [31:0] imem_addr,
    output logic [31:0] imem_in_data,
    output logic        imem_ready,
    output logic        imem_error,

    input  logic        dmem_en,
    input  logic [3:0]  dmem_wr,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_out_data,
    output logic [31:0] dmem_in_data,
    output logic        dmem_ready,
    output logic        dmem_error,

    output logic        mem_en,
    output logic [3:0]  mem_wr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_out_data,
    input  logic [31:0] mem_in_data,
    input  logic        mem_ready,
    input  logic        mem_error
);

    typedef enum logic [1:0] {StIdle, StImem, StDmem} state_e;

    state_e      state;
    logic [31:0] cnt;
    logic [31:0] streak;

    logic grant_i;
    logic grant_d;
    logic busy;
    logic timeout;
    logic done;

    // Grant decode, watchdog and same-cycle response routing to the owner
    always_comb begin
        grant_i      = (state == StImem);
        grant_d      = (state == StDmem);
        busy         = grant_i | grant_d;
        timeout      = (TIMEOUT_CYCLES != 0) && busy && (cnt == TIMEOUT_CYCLES - 32'd1);
        done         = busy & (mem_ready | mem_error | timeout);

        imem_in_data = mem_in_data;
        dmem_in_data = mem_in_data;
        // Error takes precedence over a simultaneous ready
        imem_error   = grant_i & (mem_error | timeout);
        imem_ready   = grant_i & mem_ready & ~mem_error & ~timeout;
        dmem_error   = grant_d & (mem_error | timeout);
        dmem_ready   = grant_d & mem_ready & ~mem_error & ~timeout;
    end

    // Arbitration FSM with registered bus outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= StIdle;
            mem_en       <= 1'b0;
            mem_wr       <= 4'h0;
            mem_addr     <= 32'h0;
            mem_out_data <= 32'h0;
            cnt          <= 32'h0;
            streak       <= 32'h0;
        end else begin
            unique case (state)
                StIdle: begin
                    cnt <= 32'h0;
                    if (dmem_en && (!imem_en || streak < MAX_DMEM_STREAK)) begin
                        state        <= StDmem;
                        mem_en       <= 1'b1;
                        mem_wr       <= dmem_wr;
                        mem_addr     <= dmem_addr;
                        mem_out_data <= dmem_out_data;
                        // Streak only counts data grants that bypassed a waiting fetch
                        streak       <= imem_en ? streak + 32'd1 : 32'h0;
                    end else if (imem_en) begin
                        state        <= StImem;
                        mem_en       <= 1'b1;
                        mem_wr       <= 4'h0;
                        mem_addr     <= imem_addr;
                        mem_out_data <= 32'h0;
                        streak       <= 32'h0;
                    end
                end
                StImem, StDmem: begin
                    if (done) begin
                        state  <= StIdle;
                        mem_en <= 1'b0;
                        cnt    <= 32'h0;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                default: begin
                    state  <= StIdle;
                    mem_en <= 1'b0;
                    cnt    <= 32'h0;
                end
            endcase
        end
    end

endmodule
